// File: rtl/pri_arb.sv
// Rotating-priority arbiter with a registered, non-retracting grant handshake.
// A grant stays put until valid && ready, then the search pointer moves past the winner.
// Optional feature: define PRI_ARB_LOCK_EN to add a 'lock' input that re-grants the
// current winner on acceptance while it keeps requesting.

`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module pri_arb #(
    parameter int   REQ = 8,
    parameter int   OUT = $clog2(REQ),
    parameter logic ACT = `High
) (
    input  logic           clk,
    input  logic           reset_,
    input  logic [REQ-1:0] req,
    input  logic           ready,
`ifdef PRI_ARB_LOCK_EN
    input  logic           lock,
`endif
    output logic           valid,
    output logic [REQ-1:0] grant,
    output logic [OUT-1:0] grant_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         r_state;
    logic [OUT-1:0] r_ptr;
    logic [OUT-1:0] r_gid;
    logic [REQ-1:0] r_grant;

    logic [REQ-1:0] w_reqAct;
    logic           w_any;
    logic [OUT-1:0] w_nextAfter;
    logic [OUT-1:0] w_start;
    logic [OUT-1:0] w_winner;
    logic           w_lock;
    logic           w_holdSame;

    // First active request at or after s, wrapping to index 0 (two-pass scan, no modulo).
    function automatic logic [OUT-1:0] firstFrom(input logic [REQ-1:0] r,
                                                 input logic [OUT-1:0] s);
        logic [OUT-1:0] win;
        logic           hit;
        win = '0;
        hit = 1'b0;
        for (int i = 0; i < REQ; i++) begin
            if (!hit && (i >= int'(s)) && r[i]) begin
                hit = 1'b1;
                win = OUT'(i);
            end
        end
        for (int i = 0; i < REQ; i++) begin
            if (!hit && (i < int'(s)) && r[i]) begin
                hit = 1'b1;
                win = OUT'(i);
            end
        end
        return win;
    endfunction

    // Normalise request polarity and pick the next winner from the proper starting index.
    always_comb begin
        w_reqAct    = ACT ? req : ~req;
        w_any       = |w_reqAct;
        w_nextAfter = (r_gid == OUT'(REQ - 1)) ? '0 : r_gid + OUT'(1);
        w_start     = (r_state == GRANT) ? w_nextAfter : r_ptr;
        w_winner    = firstFrom(w_reqAct, w_start);
`ifdef PRI_ARB_LOCK_EN
        w_lock      = lock;
`else
        w_lock      = 1'b0;
`endif
        w_holdSame  = w_lock && ((w_reqAct & r_grant) != '0);
    end

    // Handshake FSM: grant is loaded on entry, frozen until accepted, then reloaded or dropped.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_gid   <= w_winner;
                        r_grant <= {{(REQ-1){1'b0}}, 1'b1} << w_winner;
                    end
                end
                GRANT: begin
                    if (ready) begin
                        if (!w_lock) begin
                            r_ptr <= w_nextAfter;
                        end
                        if (w_holdSame) begin
                            r_state <= GRANT;
                        end else if (w_any) begin
                            r_state <= GRANT;
                            r_gid   <= w_winner;
                            r_grant <= {{(REQ-1){1'b0}}, 1'b1} << w_winner;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Apply the configured output polarity to the registered handshake state.
    always_comb begin
        valid    = (r_state == GRANT) ? ACT : ~ACT;
        grant    = ACT ? r_grant : ~r_grant;
        grant_id = r_gid;
    end

endmodule

// File: tb/tb_pri_arb.sv
// Directed bench for pri_arb: an 8-requester active-high instance and a
// 5-requester active-low instance, each with its own reset.

`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module tb_pri_arb;

    logic       clk;
    logic       rst8;
    logic [7:0] req8;
    logic       ready8;
    logic       valid8;
    logic [7:0] grant8;
    logic [2:0] gid8;
`ifdef PRI_ARB_LOCK_EN
    logic       lock8;
    logic       lock5;
`endif

    logic       rst5;
    logic [4:0] req5;
    logic       ready5;
    logic       valid5;
    logic [4:0] grant5;
    logic [2:0] gid5;

    int vectors;
    int errors;

    pri_arb #(.REQ(8), .ACT(`High)) dut8 (
        .clk      (clk),
        .reset_   (rst8),
        .req      (req8),
        .ready    (ready8),
`ifdef PRI_ARB_LOCK_EN
        .lock     (lock8),
`endif
        .valid    (valid8),
        .grant    (grant8),
        .grant_id (gid8)
    );

    pri_arb #(.REQ(5), .ACT(`Low)) dut5 (
        .clk      (clk),
        .reset_   (rst5),
        .req      (req5),
        .ready    (ready5),
`ifdef PRI_ARB_LOCK_EN
        .lock     (lock5),
`endif
        .valid    (valid5),
        .grant    (grant5),
        .grant_id (gid5)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge so outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset8();
        rst8 = 1'b0;
        #3;
        rst8 = 1'b1;
        #1;
    endtask

    task automatic reset5();
        rst5 = 1'b0;
        #3;
        rst5 = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst8 = 1'b0; rst5 = 1'b0;
        req8 = 8'h00; ready8 = 1'b0;
        req5 = 5'h1F; ready5 = 1'b0;
`ifdef PRI_ARB_LOCK_EN
        lock8 = 1'b0; lock5 = 1'b0;
`endif
        #12;
        vectors++;
        if ({valid8, grant8, gid8} !== {1'b0, 8'h00, 3'd0}) begin
            errors++;
            $display("[TB] FAIL reset8 got v=%b g=%h id=%0d want v=0 g=00 id=0", valid8, grant8, gid8);
        end
        vectors++;
        if ({valid5, grant5, gid5} !== {1'b1, 5'h1F, 3'd0}) begin
            errors++;
            $display("[TB] FAIL reset5 got v=%b g=%b id=%0d want v=1 g=11111 id=0", valid5, grant5, gid5);
        end
        @(negedge clk);
        rst8 = 1'b1; rst5 = 1'b1;
        #1;
    endtask

    task automatic test_alternate();
        logic [2:0] expId [3];
        logic [7:0] expG  [3];
        expId[0] = 3'd0; expId[1] = 3'd7; expId[2] = 3'd0;
        expG[0]  = 8'h01; expG[1] = 8'h80; expG[2] = 8'h01;
        req8 = 8'h81; ready8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({valid8, grant8, gid8} !== {1'b1, expG[k], expId[k]}) begin
                errors++;
                $display("[TB] FAIL alternate[%0d] got v=%b g=%h id=%0d want v=1 g=%h id=%0d",
                         k, valid8, grant8, gid8, expG[k], expId[k]);
            end
        end
        req8 = 8'h00;
        tick();
        vectors++;
        if ({valid8, grant8} !== {1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL alternate_idle got v=%b g=%h want v=0 g=00", valid8, grant8);
        end
    endtask

    task automatic test_back_to_back();
        reset8();
        req8 = 8'hFF; ready8 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            vectors++;
            if ({valid8, gid8} !== {1'b1, 3'(k % 8)}) begin
                errors++;
                $display("[TB] FAIL b2b[%0d] got v=%b id=%0d want v=1 id=%0d", k, valid8, gid8, k % 8);
            end
        end
        req8 = 8'h00;
        tick();
    endtask

    task automatic test_hold();
        reset8();
        req8 = 8'h04; ready8 = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({valid8, grant8, gid8} !== {1'b1, 8'h04, 3'd2}) begin
                errors++;
                $display("[TB] FAIL hold[%0d] got v=%b g=%h id=%0d want v=1 g=04 id=2", k, valid8, grant8, gid8);
            end
            req8 = (k % 2 == 0) ? 8'h00 : 8'hF0;
            if (k < 4) tick();
        end
        req8 = 8'h00; ready8 = 1'b1;
        tick();
        vectors++;
        if ({valid8, grant8} !== {1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL hold_release got v=%b g=%h want v=0 g=00", valid8, grant8);
        end
    endtask

    task automatic test_wrap();
        reset8();
        req8 = 8'h40; ready8 = 1'b1;
        tick();
        vectors++;
        if (gid8 !== 3'd6) begin
            errors++;
            $display("[TB] FAIL wrap8_first got id=%0d want id=6", gid8);
        end
        req8 = 8'h41;
        tick();
        vectors++;
        if ({valid8, gid8} !== {1'b1, 3'd0}) begin
            errors++;
            $display("[TB] FAIL wrap8 got v=%b id=%0d want v=1 id=0", valid8, gid8);
        end
        req8 = 8'h00;
        tick();
        ready8 = 1'b0;

        reset5();
        req5 = 5'b01111; ready5 = 1'b1;
        tick();
        vectors++;
        if ({valid5, grant5, gid5} !== {1'b0, 5'b01111, 3'd4}) begin
            errors++;
            $display("[TB] FAIL wrap5_first got v=%b g=%b id=%0d want v=0 g=01111 id=4", valid5, grant5, gid5);
        end
        req5 = 5'b00000;
        tick();
        vectors++;
        if ({valid5, grant5, gid5} !== {1'b0, 5'b11110, 3'd0}) begin
            errors++;
            $display("[TB] FAIL wrap5 got v=%b g=%b id=%0d want v=0 g=11110 id=0", valid5, grant5, gid5);
        end
        req5 = 5'b11111;
        tick();
        vectors++;
        if ({valid5, grant5} !== {1'b1, 5'b11111}) begin
            errors++;
            $display("[TB] FAIL wrap5_idle got v=%b g=%b want v=1 g=11111", valid5, grant5);
        end
        ready5 = 1'b0;
    endtask

    task automatic test_low_reset();
        reset5();
        req5 = 5'b11011; ready5 = 1'b0;
        tick();
        vectors++;
        if ({valid5, grant5, gid5} !== {1'b0, 5'b11011, 3'd2}) begin
            errors++;
            $display("[TB] FAIL low_grant got v=%b g=%b id=%0d want v=0 g=11011 id=2", valid5, grant5, gid5);
        end
        req5 = 5'b01010; ready5 = 1'b1;
        tick();
        vectors++;
        if (gid5 !== 3'd4) begin
            errors++;
            $display("[TB] FAIL low_next got id=%0d want id=4", gid5);
        end
        ready5 = 1'b0;
        #2;
        rst5 = 1'b0;
        #1;
        vectors++;
        if ({valid5, grant5, gid5} !== {1'b1, 5'b11111, 3'd0}) begin
            errors++;
            $display("[TB] FAIL low_async_reset got v=%b g=%b id=%0d want v=1 g=11111 id=0", valid5, grant5, gid5);
        end
        rst5 = 1'b1;
        tick();
        vectors++;
        if ({valid5, gid5} !== {1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL low_after_reset got v=%b id=%0d want v=0 id=0", valid5, gid5);
        end
    endtask

`ifdef PRI_ARB_LOCK_EN
    task automatic test_lock();
        reset8();
        req8 = 8'h06; lock8 = 1'b1; ready8 = 1'b0;
        tick();
        vectors++;
        if (gid8 !== 3'd1) begin
            errors++;
            $display("[TB] FAIL lock_first got id=%0d want id=1", gid8);
        end
        ready8 = 1'b1;
        tick();
        vectors++;
        if ({valid8, gid8} !== {1'b1, 3'd1}) begin
            errors++;
            $display("[TB] FAIL lock_regrant got v=%b id=%0d want v=1 id=1", valid8, gid8);
        end
        lock8 = 1'b0;
        tick();
        vectors++;
        if ({valid8, gid8} !== {1'b1, 3'd2}) begin
            errors++;
            $display("[TB] FAIL lock_release got v=%b id=%0d want v=1 id=2", valid8, gid8);
        end
        ready8 = 1'b0;
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_alternate();
        test_back_to_back();
        test_hold();
        test_wrap();
        test_low_reset();
`ifdef PRI_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
